// File: rtl/adder_sweep_if.sv
// adder_sweep_if: stimulus and result bundle between the sweep checker and the adder under test
interface adder_sweep_if #(parameter int WIDTH = 4);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ci;
    logic [WIDTH-1:0]     s;
    logic [WIDTH-2:0]     co;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2*WIDTH+1:0]   err_count;
    logic [2*WIDTH:0]     first_err_vec;
    modport master (input start, s, co, output a, b, ci, busy, done, pass, err_count, first_err_vec);
    modport slave  (output start, s, co, input a, b, ci, busy, done, pass, err_count, first_err_vec);
endinterface

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: drives every {ci,b,a} into an external adder, checks sum and internal carries
module adder_sweep_checker #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_sweep_if.master       sweep
);
    localparam int VW = 2*WIDTH+1;
    localparam int CW = 2*WIDTH+2;
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t         state_q;
    logic [VW-1:0]  vec_q, first_q, first_d;
    logic [7:0]     hc_q;
    logic [CW-1:0]  err_q, err_d;
    logic           busy_q, done_q, pass_q, fail;
    logic [WIDTH-1:0] op_a, op_b;
    logic           op_c;
    logic [WIDTH:0] sum, cin;
    assign op_a = vec_q[WIDTH-1:0];
    assign op_b = vec_q[2*WIDTH-1:WIDTH];
    assign op_c = vec_q[VW-1];
    // sum ^ a ^ b recovers the carry into each bit; carry out of bit i is carry into bit i+1
    always_comb begin
        sum     = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_c};
        cin     = sum ^ {1'b0, op_a} ^ {1'b0, op_b};
        fail    = (sweep.s != sum[WIDTH-1:0]) || (sweep.co != cin[WIDTH-1:1]);
        err_d   = err_q + CW'(fail);
        first_d = (fail && err_q == '0) ? vec_q : first_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hc_q    <= '0;
            err_q   <= '0;
            first_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (sweep.start) begin
                    state_q <= DRIVE;
                    vec_q   <= '0;
                    hc_q    <= 8'(HOLD-1);
                    err_q   <= '0;
                    first_q <= '0;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
                DRIVE: if (hc_q != '0) begin
                    hc_q <= hc_q - 8'd1;
                end else begin
                    err_q   <= err_d;
                    first_q <= first_d;
                    if (&vec_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        vec_q <= vec_q + VW'(1);
                        hc_q  <= 8'(HOLD-1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign sweep.a             = op_a;
    assign sweep.b             = op_b;
    assign sweep.ci            = op_c;
    assign sweep.busy          = busy_q;
    assign sweep.done          = done_q;
    assign sweep.pass          = pass_q;
    assign sweep.err_count     = err_q;
    assign sweep.first_err_vec = first_q;
endmodule

// File: tb/tb_adder_sweep_checker.sv
// tb_adder_sweep_checker: directed checks of the sweep checker against ideal and faulty adder models
module tb_adder_sweep_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   mode7 = 0;
    int   mode1 = 0;
    int   n;
    always #5 clk = ~clk;
    adder_sweep_if #(.WIDTH(4)) s7();
    adder_sweep_if #(.WIDTH(4)) s1();
    adder_sweep_checker #(.WIDTH(4), .HOLD(7)) dut7 (.clk(clk), .rst_n(rst_n), .sweep(s7.master));
    adder_sweep_checker #(.WIDTH(4), .HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .sweep(s1.master));
    function automatic logic [6:0] ripple(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic       c;
        logic [3:0] sm;
        logic [2:0] cc;
        c  = c0;
        sm = '0;
        cc = '0;
        for (int i = 0; i < 4; i++) begin
            sm[i] = x[i] ^ y[i] ^ c;
            c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
            if (i < 3) cc[i] = c;
        end
        return {cc, sm};
    endfunction
    logic [6:0] g7, g1, d1, d2;
    assign g7    = ripple(s7.a, s7.b, s7.ci);
    assign g1    = ripple(s1.a, s1.b, s1.ci);
    assign s7.s  = (mode7 == 1) ? (g7[3:0] & 4'b1011) : g7[3:0];
    assign s7.co = (mode7 == 2) ? (g7[6:4] ^ 3'b001) : g7[6:4];
    // two-cycle output latency model for the HOLD=1 instance
    always_ff @(posedge clk) begin
        d1 <= g1;
        d2 <= d1;
    end
    assign s1.s  = (mode1 == 1) ? d2[3:0] : g1[3:0];
    assign s1.co = (mode1 == 1) ? d2[6:4] : g1[6:4];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask
    // pulse start so it is sampled at E0, then count edges after E0 until done (bounded)
    task automatic run(input bit sel, input int repulse, output int cnt);
        @(negedge clk);
        if (sel) s1.start = 1'b1; else s7.start = 1'b1;
        @(posedge clk);
        #1;
        s1.start = 1'b0;
        s7.start = 1'b0;
        check("busy_at_e0", 32'(sel ? s1.busy : s7.busy), 32'd1);
        check("done_at_e0", 32'(sel ? s1.done : s7.done), 32'd0);
        check("vec0_at_e0", 32'(sel ? {s1.ci, s1.b, s1.a} : {s7.ci, s7.b, s7.a}), 32'd0);
        cnt = 0;
        while (!(sel ? s1.done : s7.done) && cnt < 5000) begin
            if (cnt == repulse) s7.start = 1'b1;
            @(posedge clk);
            #1;
            s7.start = 1'b0;
            cnt++;
        end
    endtask
    initial begin
        s7.start = 1'b0;
        s1.start = 1'b0;
        #23;
        check("rst_busy", 32'(s7.busy), 32'd0);
        check("rst_done", 32'(s7.done), 32'd0);
        check("rst_vec", 32'({s7.ci, s7.b, s7.a}), 32'd0);
        rst_n = 1'b1;
        // vector boundaries: vector 1 appears exactly HOLD edges after E0
        @(negedge clk);
        s7.start = 1'b1;
        @(posedge clk);
        #1;
        s7.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("vec_e0p6", 32'(s7.a), 32'd0);
        @(posedge clk);
        #1;
        check("vec_e0p7", 32'(s7.a), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mode7 = 0;
        run(1'b0, -1, n);
        check("ideal_done_cycles", 32'(n), 32'd3584);
        check("ideal_err", 32'(s7.err_count), 32'd0);
        check("ideal_pass", 32'(s7.pass), 32'd1);
        check("ideal_busy", 32'(s7.busy), 32'd0);
        check("last_vec", 32'({s7.ci, s7.b, s7.a}), 32'h1ff);
        mode7 = 1;
        run(1'b0, -1, n);
        check("s2_done_cycles", 32'(n), 32'd3584);
        check("s2_err", 32'(s7.err_count), 32'd256);
        check("s2_first", 32'(s7.first_err_vec), 32'h004);
        check("s2_pass", 32'(s7.pass), 32'd0);
        mode7 = 2;
        run(1'b0, -1, n);
        check("co0_err", 32'(s7.err_count), 32'd512);
        check("co0_first", 32'(s7.first_err_vec), 32'h000);
        check("co0_pass", 32'(s7.pass), 32'd0);
        // async reset mid-sweep with errors already accumulated
        mode7 = 1;
        @(negedge clk);
        s7.start = 1'b1;
        @(posedge clk);
        #1;
        s7.start = 1'b0;
        repeat (999) @(posedge clk);
        #3;
        check("pre_rst_err_nz", 32'(s7.err_count != 0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(s7.busy), 32'd0);
        check("arst_done", 32'(s7.done), 32'd0);
        check("arst_pass", 32'(s7.pass), 32'd0);
        check("arst_vec", 32'({s7.ci, s7.b, s7.a}), 32'd0);
        check("arst_err", 32'(s7.err_count), 32'd0);
        check("arst_first", 32'(s7.first_err_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mode7 = 0;
        run(1'b0, -1, n);
        check("post_rst_cycles", 32'(n), 32'd3584);
        check("post_rst_err", 32'(s7.err_count), 32'd0);
        check("post_rst_pass", 32'(s7.pass), 32'd1);
        // start re-pulsed while busy must not disturb timing; start in DONE restarts
        run(1'b0, 50, n);
        check("repulse_cycles", 32'(n), 32'd3584);
        check("repulse_pass", 32'(s7.pass), 32'd1);
        run(1'b0, 3, n);
        check("restart_cycles", 32'(n), 32'd3584);
        mode1 = 0;
        run(1'b1, -1, n);
        check("h1_done_cycles", 32'(n), 32'd512);
        check("h1_pass", 32'(s1.pass), 32'd1);
        check("h1_err", 32'(s1.err_count), 32'd0);
        mode1 = 1;
        run(1'b1, -1, n);
        check("h1_lat_err_nz", 32'(s1.err_count != 0), 32'd1);
        check("h1_lat_pass", 32'(s1.pass), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
